branch_target_buffer: RTL and testbench
=======================================

Name: branch_target_buffer

Overview:
- Parametrised successor to the single-outstanding jump predictor.
- Direct-mapped, tagged BTB with per-entry 2-bit saturating direction counters.
- Looks up the ID-stage PC (pcinc) and resolves RESOLVE_LAT cycles later at MEM.
- Supports up to RESOLVE_LAT predictions in flight with no busy stall; flushes its own pending state on a mispredict or an external flush.

Parameters:
- ADDR_W, 16, PC/target width.
- ENTRIES, 16, table depth; power of two, at least 2. IDX_W = clog2(ENTRIES).
- TAG_W, 4, tag width; IDX_W+TAG_W must not exceed ADDR_W.
- RESOLVE_LAT, 2, cycles from lookup to resolve; at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low (0 = reset).
- flush  in  1  pipeline squash from the core; kills all pending records.
- lookup_valid  in  1  ID stage holds a jump/branch.
- lookup_pc  in  ADDR_W  fall-through PC of the ID instruction.
- pred_taken  out  1  predict taken (combinational).
- pred_target  out  ADDR_W  predicted target (combinational).
- resolve_valid  in  1  the MEM instruction is the resolving branch.
- resolve_taken  in  1  actual direction.
- resolve_target  in  ADDR_W  actual target (ALU result).
- mispredict  out  1  redirect required (combinational).
- redirect_pc  out  ADDR_W  correct next PC when mispredict=1.

Behaviour:
- Index and tag: idx = lookup_pc[IDX_W-1:0]; tag = lookup_pc[IDX_W+TAG_W-1:IDX_W].
- Hit: hit = vld[idx] and tag_tbl[idx]==tag.
- Prediction: pred_taken = lookup_valid & !flush & hit & ctr[idx][1]. pred_target = tgt[idx], regardless of hit.
- Pending pipe: a RESOLVE_LAT-deep shift register of records {v, pred_taken, pred_target, pc, idx, tag}.
  - Stage 0 loads v = lookup_valid & !flush & !mispredict.
  - Every stage shifts each cycle; there are no stalls.
- Resolve: the tail record (tl) is used. Resolution is effective only when resolve_valid & tl.v.
  - If resolve_valid arrives with tl.v=0: ignored; no update and no mispredict.
- mispredict = effective & (resolve_taken != tl.pred_taken | (resolve_taken & resolve_target != tl.pred_target)).
- redirect_pc = resolve_taken ? resolve_target : tl.pc. The value is don't-care when mispredict=0.
- Squash: when mispredict=1 or flush=1, all pending v bits clear at the next edge, including the record being written into stage 0 that cycle.
- Table update on an effective resolve. The entry hits if vld[tl.idx] & tag_tbl[tl.idx]==tl.tag.
  - Entry hits: ctr saturating +1 if taken, else -1 (range 0..3). tgt is written with resolve_target if taken.
  - Entry misses and taken: allocate. vld=1, tag=tl.tag, tgt=resolve_target, ctr=2 (weakly taken).
  - Entry misses and not taken: no change.
- Same-cycle update and lookup of the same idx: the lookup sees the pre-update contents (read-before-write).
- Reset:
  - vld all 0 and all pending v = 0. Outputs are therefore pred_taken=0 and mispredict=0.
  - tgt, tag_tbl and ctr are not reset; they are gated by vld.
  - Reset asserted mid-flight discards all pending records.
- flush and resolve in the same cycle: the resolve still updates the table and still drives mispredict.

Optional Feature:
- Macro: BTB_STATS_EN.
- When defined, add outputs stat_lookups (32-bit) and stat_mispredicts (32-bit).
  - stat_lookups counts cycles with lookup_valid & !flush.
  - stat_mispredicts counts cycles with mispredict=1.
  - Both counters saturate at all-ones and are cleared by reset.
- When undefined: these ports and counters are absent, and core behaviour is identical.

Decomposition:
- Package bp_pkg holds:
  - typedef pend_rec_t (packed struct of the pending record).
  - constants CTR_W=2, CTR_WEAK_TAKEN=2'd2, CTR_MAX=2'd3.
  - function sat_update(ctr, taken).
- Sub-module btb_pend_pipe: the RESOLVE_LAT-deep record shift register with synchronous squash. It exposes stage-0 write and tail read.

Test Plan (ENTRIES=16, TAG_W=4, RESOLVE_LAT=2):
- Cold miss: after reset, lookup pc 0x0013, then resolve taken to 0x0200 two cycles later.
  - At lookup: pred_taken=0.
  - At resolve: mispredict=1, redirect_pc=0x0200.
  - Entry 3 becomes vld with ctr=2. A relookup of 0x0013 gives pred_taken=1, pred_target=0x0200.
- Counter hysteresis on entry 3 (ctr=2):
  - One not-taken resolve gives mispredict=1, redirect_pc=0x0013, ctr=1.
  - The next lookup predicts not-taken. Two taken resolves give ctr=3.
  - The counter never exceeds 3 or falls below 0.
- Tag alias: with entry 3 tagged for 0x0013, lookup 0x0023 gives pred_taken=0.
  - A taken resolve to 0x0400 reallocates entry 3 with tag 2.
  - A subsequent lookup of 0x0013 misses.
- Target change: predicted taken to 0x0200, actual taken to 0x0300.
  - Result: mispredict=1, redirect_pc=0x0300, tgt[3]=0x0300.
- Back-to-back and squash: lookups on 3 consecutive cycles, with the first resolving mispredicted.
  - The 2nd and 3rd records are squashed; their resolve_valid is ignored, with no update and no mispredict.
- Reset mid-flight and flush: assert reset=0 with 2 records pending, then release.
  - No mispredict fires. All lookups miss until reallocated.
  - flush=1 during a lookup: pred_taken=0 and no record is created.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target buffer: pending-record layout,
// direction-counter constants and the saturating counter update.
package bp_pkg;

  // Record fields are sized for the widest supported PC; unused upper bits are constant.
  localparam int BP_MAX_W = 32;

  localparam int             CTR_W          = 2;
  localparam logic [CTR_W-1:0] CTR_WEAK_TAKEN = 2'd2;
  localparam logic [CTR_W-1:0] CTR_MAX        = 2'd3;

  typedef struct packed {
    logic                v;
    logic                pred_taken;
    logic [BP_MAX_W-1:0] pred_target;
    logic [BP_MAX_W-1:0] pc;
    logic [BP_MAX_W-1:0] idx;
    logic [BP_MAX_W-1:0] tag;
  } pend_rec_t;

  function automatic logic [CTR_W-1:0] sat_update(input logic [CTR_W-1:0] ctr,
                                                  input logic             taken);
    if (taken) begin
      return (ctr == CTR_MAX) ? ctr : ctr + 2'd1;
    end
    return (ctr == '0) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_pend_pipe.sv
// Fixed-latency shift register of in-flight predictions; no stalls, one record per cycle.
// squash or reset clears every valid bit at the next edge, including the record entering stage 0.
module btb_pend_pipe
  import bp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      squash,
  input  pend_rec_t stage0_d,
  output pend_rec_t tail_o
);

  pend_rec_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    stage_q[0] <= stage0_d;
    for (int i = 1; i < DEPTH; i++) begin
      stage_q[i] <= stage_q[i-1];
    end
    if (!reset || squash) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i].v <= 1'b0;
      end
    end
  end

  assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped tagged BTB with 2-bit direction counters; predicts at ID, resolves RESOLVE_LAT cycles later.
// Define BTB_STATS_EN to add saturating lookup/mispredict counters.
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int ENTRIES     = 16,
  parameter int TAG_W       = 4,
  parameter int RESOLVE_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  input  logic [ADDR_W-1:0] resolve_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] vld_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_act;
  logic             lk_hit;

  assign lk_idx      = lookup_pc[IDX_W-1:0];
  assign lk_tag      = lookup_pc[IDX_W+TAG_W-1:IDX_W];
  assign lk_act      = lookup_valid & ~flush;
  assign lk_hit      = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_act & lk_hit & ctr_q[lk_idx][CTR_W-1];
  assign pred_target = tgt_q[lk_idx];

  pend_rec_t stage0_d;
  pend_rec_t tl;

  always_comb begin
    stage0_d             = '0;
    stage0_d.v           = lk_act & ~mispredict;
    stage0_d.pred_taken  = pred_taken;
    stage0_d.pred_target = BP_MAX_W'(pred_target);
    stage0_d.pc          = BP_MAX_W'(lookup_pc);
    stage0_d.idx         = BP_MAX_W'(lk_idx);
    stage0_d.tag         = BP_MAX_W'(lk_tag);
  end

  btb_pend_pipe #(
    .DEPTH (RESOLVE_LAT)
  ) u_pend (
    .clk      (clk),
    .reset    (reset),
    .squash   (mispredict | flush),
    .stage0_d (stage0_d),
    .tail_o   (tl)
  );

  logic [IDX_W-1:0]  rs_idx;
  logic [TAG_W-1:0]  rs_tag;
  logic [ADDR_W-1:0] rs_pc;
  logic [ADDR_W-1:0] rs_ptgt;
  logic              rs_eff;
  logic              rs_hit;
  logic              unused_tl;

  assign rs_idx    = tl.idx[IDX_W-1:0];
  assign rs_tag    = tl.tag[TAG_W-1:0];
  assign rs_pc     = tl.pc[ADDR_W-1:0];
  assign rs_ptgt   = tl.pred_target[ADDR_W-1:0];
  assign unused_tl = ^tl;

  // A resolve with no live record behind it (squashed or never issued) is dropped entirely.
  assign rs_eff      = resolve_valid & tl.v;
  assign rs_hit      = vld_q[rs_idx] && (tag_q[rs_idx] == rs_tag);
  assign mispredict  = rs_eff & ((resolve_taken != tl.pred_taken) |
                                 (resolve_taken & (resolve_target != rs_ptgt)));
  assign redirect_pc = resolve_taken ? resolve_target : rs_pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
    end else if (rs_eff) begin
      if (rs_hit) begin
        ctr_q[rs_idx] <= sat_update(ctr_q[rs_idx], resolve_taken);
        if (resolve_taken) begin
          tgt_q[rs_idx] <= resolve_target;
        end
      end else if (resolve_taken) begin
        vld_q[rs_idx] <= 1'b1;
        tag_q[rs_idx] <= rs_tag;
        tgt_q[rs_idx] <= resolve_target;
        ctr_q[rs_idx] <= CTR_WEAK_TAKEN;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookups_q, lookups_d;
  logic [31:0] mispred_q, mispred_d;

  always_comb begin
    lookups_d = lookups_q;
    mispred_d = mispred_q;
    if (lk_act && (lookups_q != '1)) lookups_d = lookups_q + 32'd1;
    if (mispredict && (mispred_q != '1)) mispred_d = mispred_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      lookups_q <= lookups_d;
      mispred_q <= mispred_d;
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_mispredicts = mispred_q;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Vector-table bench for branch_target_buffer: each row is one cycle; resolve expectations
// ride a scoreboard queue and are applied and checked two cycles after their lookup.
module tb_branch_target_buffer;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset, flush, lookup_valid;
  logic [15:0] lookup_pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        resolve_valid, resolve_taken;
  logic [15:0] resolve_target;
  logic        mispredict;
  logic [15:0] redirect_pc;

  always #5 clk = ~clk;

  branch_target_buffer #(
    .ADDR_W(16), .ENTRIES(16), .TAG_W(4), .RESOLVE_LAT(LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .lookup_valid   (lookup_valid),
    .lookup_pc      (lookup_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .resolve_target (resolve_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc)
  );

  typedef struct {
    bit          rst;
    bit          fl;
    bit          lv;
    logic [15:0] pc;
    bit          ept;
    bit          ctgt;
    logic [15:0] etgt;
    bit          ren;
    bit          rtk;
    logic [15:0] rtgt;
    bit          emp;
    logic [15:0] erpc;
  } vec_t;

  typedef struct {
    int          due;
    bit          tk;
    logic [15:0] tgt;
    bit          emp;
    logic [15:0] erpc;
  } res_t;

  vec_t vecs[$];
  res_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input bit rst, input bit fl, input bit lv, input logic [15:0] pc,
                     input bit ept, input bit ctgt, input logic [15:0] etgt,
                     input bit ren, input bit rtk, input logic [15:0] rtgt,
                     input bit emp, input logic [15:0] erpc);
    vec_t v;
    v.rst = rst; v.fl = fl; v.lv = lv; v.pc = pc;
    v.ept = ept; v.ctgt = ctgt; v.etgt = etgt;
    v.ren = ren; v.rtk = rtk; v.rtgt = rtgt; v.emp = emp; v.erpc = erpc;
    vecs.push_back(v);
  endtask

  task automatic idl();
    add(0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
  endtask

  task automatic lk(input logic [15:0] pc, input bit ept, input bit ctgt, input logic [15:0] etgt);
    add(0, 0, 1, pc, ept, ctgt, etgt, 0, 0, 16'h0, 0, 16'h0);
  endtask

  task automatic lkr(input logic [15:0] pc, input bit ept, input bit ctgt, input logic [15:0] etgt,
                     input bit rtk, input logic [15:0] rtgt, input bit emp, input logic [15:0] erpc);
    add(0, 0, 1, pc, ept, ctgt, etgt, 1, rtk, rtgt, emp, erpc);
  endtask

  task automatic chk(input int c, input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL c%0d %s: got %h want %h", c, name, got, want);
    end
  endtask

  initial begin
    // reset state; a lookup during reset must leave no record behind
    add(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
    add(1, 0, 1, 16'h0013, 0, 0, 16'h0, 1, 1, 16'h0200, 0, 16'h0);
    idl(); idl();
    // cold miss then allocate
    lkr(16'h0013, 0, 0, 16'h0, 1, 16'h0200, 1, 16'h0200);
    idl(); idl();
    // hysteresis: 2 -> 1 -> 2 -> 3 (saturate twice)
    lkr(16'h0013, 1, 1, 16'h0200, 0, 16'h0, 1, 16'h0013);
    idl(); idl();
    lkr(16'h0013, 0, 1, 16'h0200, 1, 16'h0200, 1, 16'h0200);
    idl(); idl();
    lkr(16'h0013, 1, 1, 16'h0200, 1, 16'h0200, 0, 16'h0);
    lkr(16'h0013, 1, 1, 16'h0200, 1, 16'h0200, 0, 16'h0);
    lkr(16'h0013, 1, 1, 16'h0200, 1, 16'h0200, 0, 16'h0);
    idl(); idl();
    // walk down 3 -> 2 -> 1 -> 0 -> 0, then back to 1 (no wrap either way)
    lkr(16'h0013, 1, 1, 16'h0200, 0, 16'h0, 1, 16'h0013);
    idl(); idl();
    lkr(16'h0013, 1, 1, 16'h0200, 0, 16'h0, 1, 16'h0013);
    idl(); idl();
    lkr(16'h0013, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    lkr(16'h0013, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    lkr(16'h0013, 0, 0, 16'h0, 1, 16'h0200, 1, 16'h0200);
    idl(); idl();
    lkr(16'h0013, 0, 0, 16'h0, 1, 16'h0200, 1, 16'h0200);
    idl(); idl();
    // tag alias reallocates entry 3
    lkr(16'h0023, 0, 1, 16'h0200, 1, 16'h0400, 1, 16'h0400);
    idl(); idl();
    lkr(16'h0013, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    lkr(16'h0023, 1, 1, 16'h0400, 1, 16'h0400, 0, 16'h0);
    idl(); idl();
    // target change
    lkr(16'h0013, 0, 0, 16'h0, 1, 16'h0200, 1, 16'h0200);
    idl(); idl();
    lkr(16'h0013, 1, 1, 16'h0200, 1, 16'h0300, 1, 16'h0300);
    idl(); idl();
    lkr(16'h0013, 1, 1, 16'h0300, 1, 16'h0300, 0, 16'h0);
    idl(); idl();
    // back-to-back with squash of the two younger records
    lkr(16'h0013, 1, 1, 16'h0300, 0, 16'h0, 1, 16'h0013);
    lkr(16'h0013, 1, 1, 16'h0300, 1, 16'h0700, 0, 16'h0);
    lkr(16'h0013, 1, 1, 16'h0300, 1, 16'h0700, 0, 16'h0);
    idl(); idl();
    lk(16'h0013, 1, 1, 16'h0300);
    // reset mid-flight
    lk(16'h0013, 1, 1, 16'h0300);
    lkr(16'h0013, 1, 1, 16'h0300, 1, 16'h0900, 0, 16'h0);
    add(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
    lkr(16'h0013, 0, 0, 16'h0, 1, 16'h0200, 1, 16'h0200);
    lk(16'h0023, 0, 0, 16'h0);
    idl();
    lk(16'h0013, 1, 1, 16'h0200);
    // flush during lookup, then flush coinciding with a resolve
    add(0, 1, 1, 16'h0013, 0, 0, 16'h0, 1, 1, 16'h0500, 0, 16'h0);
    idl(); idl();
    lkr(16'h0013, 1, 1, 16'h0200, 1, 16'h0600, 1, 16'h0600);
    idl();
    add(0, 1, 0, 16'h0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
    lk(16'h0013, 1, 1, 16'h0600);
    lk(16'h0005, 0, 0, 16'h0);
    idl(); idl();

    reset = 1'b0; flush = 1'b0; lookup_valid = 1'b0; lookup_pc = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;

    for (int c = 0; c < vecs.size(); c++) begin
      vec_t v;
      res_t r;
      bit   have_res;
      @(negedge clk);
      v = vecs[c];
      reset        = ~v.rst;
      flush        = v.fl;
      lookup_valid = v.lv;
      lookup_pc    = v.pc;
      resolve_valid  = 1'b0;
      resolve_taken  = 1'b0;
      resolve_target = '0;
      have_res = 1'b0;
      if (v.ren) sb.push_back('{c + LAT, v.rtk, v.rtgt, v.emp, v.erpc});
      if (sb.size() > 0 && sb[0].due == c) begin
        r = sb.pop_front();
        have_res       = 1'b1;
        resolve_valid  = 1'b1;
        resolve_taken  = r.tk;
        resolve_target = r.tgt;
      end
      #2;
      chk(c, "pred_taken", {15'd0, pred_taken}, {15'd0, v.ept});
      if (v.ctgt) chk(c, "pred_target", pred_target, v.etgt);
      if (have_res) begin
        chk(c, "mispredict", {15'd0, mispredict}, {15'd0, r.emp});
        if (r.emp) chk(c, "redirect_pc", redirect_pc, r.erpc);
      end
    end

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d resolves left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
